lamp_sequence_generator: RTL and testbench

- Drives three lamp lines l1, l2, l3 through the ordered sequence l1 → l2 → l3.
- Serves as the stimulus side of the lamp sequence-detector alarm: the transmitter end of the same lamp interface.
- Each lamp is held for a programmable number of cycles, and the whole sequence can repeat.
- Sequences are started with a start/busy/done handshake.
- A deliberately broken sequence (l2 skipped) can be generated for negative testing of detector logic.

---
 rtl/lamp_sequence_generator.sv | 178 +++++++++++++++++
 tb/tb_lamp_sequence_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lamp_sequence_generator.sv
// lamp_sequence_generator
// Transmitter side of the lamp interface: drives l1 -> l2 -> l3, each lamp
// held for a latched number of cycles, repeated reps+1 times, with a
// start/busy/done handshake and an optional invalid (l2-skipped) sequence.
// Optional feature macro: LAMP_GAP_EN inserts a one-cycle all-off GAP state
// between consecutive lamps and at the repetition boundary.
module lamp_sequence_generator #(
  parameter int HOLD_W = 4,
  parameter int REP_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [REP_W-1:0]  reps,
  input  logic              skip_l2,
  output logic              l1,
  output logic              l2,
  output logic              l3,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LAMP1 = 3'd1;
  localparam logic [2:0] LAMP2 = 3'd2;
  localparam logic [2:0] LAMP3 = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
`ifdef LAMP_GAP_EN
  localparam logic [2:0] GAP   = 3'd5;
`endif

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0]  REP_ZERO  = {REP_W{1'b0}};
  localparam logic [REP_W-1:0]  REP_ONE   = {{(REP_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r, state_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [REP_W-1:0]  rep_cnt_r, rep_cnt_s;
  logic              skip_r, skip_s;
  logic              leave_s;
  logic [2:0]        target_s;
  logic [HOLD_W-1:0] hold_eff_s;
`ifdef LAMP_GAP_EN
  logic [2:0]        gap_tgt_r, gap_tgt_s;
`endif

  // Next-state, counter and configuration-latch logic of the sequencer.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    hold_s     = hold_r;
    rep_cnt_s  = rep_cnt_r;
    skip_s     = skip_r;
    leave_s    = 1'b0;
    target_s   = IDLE;
    hold_eff_s = (hold_len == HOLD_ZERO) ? HOLD_ONE : hold_len;
`ifdef LAMP_GAP_EN
    gap_tgt_s  = gap_tgt_r;
`endif
    case (state_r)
      IDLE: begin
        // abort in IDLE swallows a simultaneous start
        if (!abort && start) begin
          hold_s     = hold_eff_s;
          rep_cnt_s  = reps;
          skip_s     = skip_l2;
          hold_cnt_s = hold_eff_s - HOLD_ONE;
          state_s    = LAMP1;
        end else begin
          state_s = IDLE;
        end
      end
      LAMP1: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hold_cnt_r == HOLD_ZERO) begin
          leave_s  = 1'b1;
          target_s = skip_r ? LAMP3 : LAMP2;
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      LAMP2: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hold_cnt_r == HOLD_ZERO) begin
          leave_s  = 1'b1;
          target_s = LAMP3;
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      LAMP3: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hold_cnt_r == HOLD_ZERO) begin
          if (rep_cnt_r != REP_ZERO) begin
            leave_s   = 1'b1;
            target_s  = LAMP1;
            rep_cnt_s = rep_cnt_r - REP_ONE;
          end else begin
            // last pass goes straight to DONE, never through a gap
            state_s = DONE;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      DONE: begin
        // abort cannot suppress the completion pulse
        state_s = IDLE;
      end
`ifdef LAMP_GAP_EN
      GAP: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          state_s = gap_tgt_r;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase

    // Lamp-to-lamp hand-over: reload the hold counter for the next lamp.
    if (leave_s) begin
      hold_cnt_s = hold_r - HOLD_ONE;
`ifdef LAMP_GAP_EN
      gap_tgt_s  = target_s;
      state_s    = GAP;
`else
      state_s    = target_s;
`endif
    end else begin
      hold_cnt_s = hold_cnt_s;
    end
  end

  // State, counters, latched config and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= HOLD_ZERO;
      hold_r     <= HOLD_ZERO;
      rep_cnt_r  <= REP_ZERO;
      skip_r     <= 1'b0;
`ifdef LAMP_GAP_EN
      gap_tgt_r  <= IDLE;
`endif
      l1         <= 1'b0;
      l2         <= 1'b0;
      l3         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      hold_r     <= hold_s;
      rep_cnt_r  <= rep_cnt_s;
      skip_r     <= skip_s;
`ifdef LAMP_GAP_EN
      gap_tgt_r  <= gap_tgt_s;
`endif
      l1         <= (state_s == LAMP1);
      l2         <= (state_s == LAMP2);
      l3         <= (state_s == LAMP3);
      busy       <= (state_s != IDLE);
      done       <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_lamp_sequence_generator.sv
// Self-checking bench for lamp_sequence_generator: expected per-cycle output
// vectors {l1,l2,l3,busy,done} are generated from the sequence rules and
// queued at start, then popped and compared every cycle.
module tb_lamp_sequence_generator;

  localparam int HOLD_W = 4;
  localparam int REP_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [HOLD_W-1:0] hold_len = '0;
  logic [REP_W-1:0]  reps = '0;
  logic              skip_l2 = 1'b0;
  logic              l1, l2, l3, busy, done;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [HOLD_W-1:0] hold;
    logic [REP_W-1:0]  rp;
    logic              skip;
    logic              change;
  } vec_t;

  vec_t vecs[7];

  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_L1   = 5'b10010;
  localparam logic [4:0] V_L2   = 5'b01010;
  localparam logic [4:0] V_L3   = 5'b00110;
  localparam logic [4:0] V_GAP  = 5'b00010;
  localparam logic [4:0] V_DONE = 5'b00011;

  lamp_sequence_generator #(.HOLD_W(HOLD_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .hold_len(hold_len), .reps(reps), .skip_l2(skip_l2),
    .l1(l1), .l2(l2), .l3(l3), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected vectors for a complete run, built from the sequence rules.
  task automatic push_run(input int h_in, input int r, input bit s);
    int h;
    h = (h_in == 0) ? 1 : h_in;
    for (int p = 0; p <= r; p++) begin
      push_n(V_L1, h);
`ifdef LAMP_GAP_EN
      push_n(V_GAP, 1);
`endif
      if (!s) begin
        push_n(V_L2, h);
`ifdef LAMP_GAP_EN
        push_n(V_GAP, 1);
`endif
      end
      push_n(V_L3, h);
`ifdef LAMP_GAP_EN
      if (p < r) push_n(V_GAP, 1);
`endif
    end
    push_n(V_DONE, 1);
  endtask

  // Pop one expectation, compare against current outputs, advance a cycle.
  task automatic check(input string name);
    logic [4:0] e, a;
    a = {l1, l2, l3, busy, done};
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: expectation queue empty, got %b", name, a);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s @%0t: got {l1,l2,l3,busy,done}=%b required %b", name, $time, a, e);
      end
    end
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) check(name);
  endtask

  initial begin
    vecs[0] = '{hold: 4'd3,  rp: 3'd0, skip: 1'b0, change: 1'b0};
    vecs[1] = '{hold: 4'd0,  rp: 3'd2, skip: 1'b0, change: 1'b0};
    vecs[2] = '{hold: 4'd2,  rp: 3'd0, skip: 1'b1, change: 1'b1};
    vecs[3] = '{hold: 4'd15, rp: 3'd0, skip: 1'b0, change: 1'b0};
    vecs[4] = '{hold: 4'd1,  rp: 3'd7, skip: 1'b0, change: 1'b1};
    vecs[5] = '{hold: 4'd1,  rp: 3'd7, skip: 1'b1, change: 1'b0};
    vecs[6] = '{hold: 4'd1,  rp: 3'd1, skip: 1'b0, change: 1'b0};

    // reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    push_n(V_IDLE, 2);
    drain("reset");

    // table-driven complete runs
    foreach (vecs[k]) begin
      hold_len = vecs[k].hold;
      reps     = vecs[k].rp;
      skip_l2  = vecs[k].skip;
      start    = 1'b1;
      push_run(int'(vecs[k].hold), int'(vecs[k].rp), vecs[k].skip);
      push_n(V_IDLE, 1);
      tick();
      start = 1'b0;
      if (vecs[k].change) begin
        hold_len = HOLD_W'($urandom_range(0, 15));
        reps     = REP_W'($urandom_range(0, 7));
        skip_l2  = ~skip_l2;
      end
      drain($sformatf("run%0d", k));
    end

    // abort in 2nd cycle of LAMP2, start during LAMP1 ignored
    hold_len = 4'd4; reps = 3'd0; skip_l2 = 1'b0;
    start = 1'b1;
    push_n(V_L1, 4); push_n(V_L2, 2); push_n(V_IDLE, 3);
    tick();
    start = 1'b0;
    check("abort_l1");
    start = 1'b1;
    check("abort_l1_start");
    start = 1'b0;
    check("abort_l1"); check("abort_l1"); check("abort_l2");
    abort = 1'b1;
    check("abort_l2");
    abort = 1'b0;
    drain("abort_after");

    // reset during LAMP3, then start in first cycle after reset
    hold_len = 4'd2; reps = 3'd0; skip_l2 = 1'b0;
    start = 1'b1;
    push_n(V_L1, 2); push_n(V_L2, 2); push_n(V_L3, 1); push_n(V_IDLE, 1);
    push_run(2, 0, 1'b0); push_n(V_IDLE, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) check("rst_pre");
    reset = 1'b1;
    check("rst_l3");
    reset = 1'b0;
    start = 1'b1;
    check("rst_after");
    start = 1'b0;
    drain("rst_restart");

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    push_n(V_IDLE, 3);
    tick();
    start = 1'b0; abort = 1'b0;
    drain("start_abort_idle");

    // abort in DONE still pulses done
    hold_len = 4'd1; reps = 3'd0; skip_l2 = 1'b1;
    start = 1'b1;
    push_run(1, 0, 1'b1); push_n(V_IDLE, 1);
    tick();
    start = 1'b0;
    check("done_abort"); check("done_abort");
    abort = 1'b1;
    check("done_abort_pulse");
    abort = 1'b0;
    drain("done_abort_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
